// File: rtl/ram_sync_pkg.sv
// Shared types and default widths for the RAM-domain CPU access synchronizers.
package ram_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } rd_state_e;

  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_DATA_WIDTH = 16;

endpackage

// File: rtl/read_request_sync_toggle_sync_edge.sv
// Two-flop synchronizer for a cross-domain toggle, plus a history flop that
// turns each toggle flip into a one-cycle req_edge pulse.
module toggle_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic toggle,
  output logic req_edge
);

  logic sync_0, sync_1, prev_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_0    <= 1'b0;
      sync_1    <= 1'b0;
      prev_sync <= 1'b0;
    end else begin
      sync_0    <= toggle;
      sync_1    <= sync_0;
      prev_sync <= sync_1;
    end
  end

  assign req_edge = sync_1 ^ prev_sync;

endmodule

// File: rtl/read_request_sync.sv
// RAM-domain responder for CPU reads: sync the request toggle, issue one read
// strobe (yielding to writes), wait the RAM latency, capture data, flip ack.
module read_request_sync
  import ram_sync_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  ram_clock,
  input  logic                  ram_reset_n,
  input  logic                  cpu_read_toggle,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  ram_write_busy,
  output logic                  ram_read_enable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic                  cpu_read_ack_toggle,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CW = $clog2(RAM_LATENCY + 1);
  localparam logic [CW-1:0] LAT_INIT = CW'(RAM_LATENCY);
  localparam logic [CW-1:0] LAT_LAST = CW'(1);

  rd_state_e     state;
  logic [CW-1:0] lat_cnt;
  logic          req_edge;

  toggle_sync_edge u_sync (
    .clk      (ram_clock),
    .rst_n    (ram_reset_n),
    .toggle   (cpu_read_toggle),
    .req_edge (req_edge)
  );

  always_ff @(posedge ram_clock or negedge ram_reset_n) begin
    if (!ram_reset_n) begin
      state               <= IDLE;
      lat_cnt             <= '0;
      ram_read_enable     <= 1'b0;
      ram_addr            <= '0;
      cpu_read_data       <= '0;
      cpu_read_ack_toggle <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_edge) begin
            ram_addr <= cpu_addr;
            if (!ram_write_busy) begin
              ram_read_enable <= 1'b1;
              lat_cnt         <= LAT_INIT;
              state           <= WAIT;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (req_edge) overrun <= 1'b1;
          if (!ram_write_busy) begin
            ram_read_enable <= 1'b1;
            lat_cnt         <= LAT_INIT;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (req_edge) overrun <= 1'b1;
          // The edge that drops the strobe is when the RAM samples it, so the
          // latency count only starts running on the following edge.
          if (ram_read_enable) begin
            ram_read_enable <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - LAT_LAST;
            if (lat_cnt == LAT_LAST) begin
              cpu_read_data       <= ram_read_data;
              cpu_read_ack_toggle <= ~cpu_read_ack_toggle;
              state               <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_read_request_sync.sv
// Scoreboard bench: stimulus queues expected {data, capture edge}; monitors
// pop on every ack toggle flip. Covers RAM_LATENCY=1 and RAM_LATENCY=4.
module tb_read_request_sync;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [14:0] a);
    case (a)
      15'h0123: mem_rd = 16'hA5A5;
      15'h7FFF: mem_rd = 16'hFFFF;
      default:  mem_rd = {a[7:0], ~a[7:0]};
    endcase
  endfunction

  // ---------------- DUT with RAM_LATENCY = 1 ----------------
  logic        rst1 = 1'b0, tog1 = 1'b0, wb1 = 1'b0;
  logic [14:0] ca1 = '0;
  logic        rre1, ack1, busy1, ovr1;
  logic [14:0] ra1;
  logic [15:0] rd1, d1;

  read_request_sync #(.ADDR_WIDTH(15), .DATA_WIDTH(16), .RAM_LATENCY(1)) u1 (
    .ram_clock(clk), .ram_reset_n(rst1), .cpu_read_toggle(tog1), .cpu_addr(ca1),
    .ram_write_busy(wb1), .ram_read_enable(rre1), .ram_addr(ra1), .ram_read_data(rd1),
    .cpu_read_data(d1), .cpu_read_ack_toggle(ack1), .busy(busy1), .overrun(ovr1)
  );

  // RAM model: data is only valid for exactly one cycle, poison otherwise
  always @(posedge clk) rd1 <= rre1 ? mem_rd(ra1) : 16'hDEAD;

  // ---------------- DUT with RAM_LATENCY = 4 ----------------
  logic        rst4 = 1'b0, tog4 = 1'b0, wb4 = 1'b0;
  logic [14:0] ca4 = '0;
  logic        rre4, ack4, busy4, ovr4;
  logic [14:0] ra4;
  logic [15:0] p4 [4];
  logic [15:0] d4;

  read_request_sync #(.ADDR_WIDTH(15), .DATA_WIDTH(16), .RAM_LATENCY(4)) u4 (
    .ram_clock(clk), .ram_reset_n(rst4), .cpu_read_toggle(tog4), .cpu_addr(ca4),
    .ram_write_busy(wb4), .ram_read_enable(rre4), .ram_addr(ra4), .ram_read_data(p4[3]),
    .cpu_read_data(d4), .cpu_read_ack_toggle(ack4), .busy(busy4), .overrun(ovr4)
  );

  always @(posedge clk) begin
    p4[0] <= rre4 ? mem_rd(ra4) : 16'hDEAD;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end

  // ---------------- scoreboards / monitors ----------------
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  logic last1 = 1'b0, last4 = 1'b0;

  always @(negedge clk) begin
    if (!rst1) last1 = 1'b0;
    else if (ack1 !== last1) begin
      last1 = ack1;
      if (q1.size() == 0) chk("ack1_unexpected", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("data1", 32'(d1), 32'(e1.data));
        chk("edge1", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst4) last4 = 1'b0;
    else if (ack4 !== last4) begin
      last4 = ack4;
      if (q4.size() == 0) chk("ack4_unexpected", 32'd1, 32'd0);
      else begin
        e4 = q4.pop_front();
        chk("data4", 32'(d4), 32'(e4.data));
        chk("edge4", 32'(cyc), 32'(e4.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  int t0;

  initial begin
    // Reset with the CPU toggle already high
    tog1 = 1'b1; ca1 = 15'h0042;
    step(3);
    mid();
    chk("rst_rre", 32'(rre1), 32'd0);
    chk("rst_addr", 32'(ra1), 32'd0);
    chk("rst_data", 32'(d1), 32'd0);
    chk("rst_ack", 32'(ack1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_ovr", 32'(ovr1), 32'd0);
    chk("rst4_busy", 32'(busy4), 32'd0);
    step(1);
    t0 = cyc; rst1 = 1'b1; rst4 = 1'b1;
    q1.push_back('{16'h42BD, t0 + 5});
    step(10);
    chk("rst_ack_after", 32'(ack1), 32'd1);

    // Basic read, latency 1
    t0 = cyc; ca1 = 15'h0123; tog1 = ~tog1;
    q1.push_back('{16'hA5A5, t0 + 5});
    step(2); mid();
    chk("basic_rre_e2", 32'(rre1), 32'd0);
    step(1); mid();
    chk("basic_rre_e3", 32'(rre1), 32'd1);
    chk("basic_addr", 32'(ra1), 32'h0123);
    chk("basic_busy", 32'(busy1), 32'd1);
    step(1); mid();
    chk("basic_rre_e4", 32'(rre1), 32'd0);
    step(4);
    chk("basic_ack", 32'(ack1), 32'd0);

    // Write conflict: busy sampled high at E3, E4, E5
    t0 = cyc; ca1 = 15'h0010; tog1 = ~tog1;
    q1.push_back('{16'h10EF, t0 + 8});
    step(2); wb1 = 1'b1;
    step(1); mid();
    chk("wc_rre_e3", 32'(rre1), 32'd0);
    chk("wc_addr_latched", 32'(ra1), 32'h0010);
    chk("wc_busy", 32'(busy1), 32'd1);
    step(2); wb1 = 1'b0;
    mid();
    chk("wc_rre_e5", 32'(rre1), 32'd0);
    step(1); mid();
    chk("wc_rre_e6", 32'(rre1), 32'd1);
    step(1); mid();
    chk("wc_rre_e7", 32'(rre1), 32'd0);
    step(1); mid();
    chk("wc_ack", 32'(ack1), 32'd1);

    // Back-to-back, two cycles after the previous ack
    step(2);
    t0 = cyc; ca1 = 15'h7FFF; tog1 = ~tog1;
    q1.push_back('{16'hFFFF, t0 + 5});
    step(8);
    chk("b2b_ack", 32'(ack1), 32'd0);
    chk("b2b_ovr", 32'(ovr1), 32'd0);

    // Overrun: second flip lands while the first read is in WAIT
    t0 = cyc; ca1 = 15'h0200; tog1 = ~tog1;
    q1.push_back('{16'h00FF, t0 + 5});
    step(2); ca1 = 15'h0300; tog1 = ~tog1;
    step(4); mid();
    chk("ovr_set", 32'(ovr1), 32'd1);
    step(12);
    chk("ovr_sticky", 32'(ovr1), 32'd1);
    chk("ovr_ack_once", 32'(ack1), 32'd1);
    chk("ovr_data_kept", 32'(d1), 32'h00FF);
    chk("ovr_idle", 32'(busy1), 32'd0);

    // Latency 4: capture at E8
    t0 = cyc; ca4 = 15'h0123; tog4 = ~tog4;
    q4.push_back('{16'hA5A5, t0 + 8});
    step(3); mid();
    chk("l4_rre", 32'(rre4), 32'd1);
    chk("l4_addr", 32'(ra4), 32'h0123);
    step(10);
    chk("l4_ack", 32'(ack4), 32'd1);

    // Reset in WAIT aborts the read
    t0 = cyc; ca4 = 15'h0456; tog4 = ~tog4;
    step(5); mid();
    chk("l4_busy_wait", 32'(busy4), 32'd1);
    #1; rst4 = 1'b0; tog4 = 1'b0;
    #1;
    chk("abort_ack", 32'(ack4), 32'd0);
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_data", 32'(d4), 32'd0);
    step(3);
    rst4 = 1'b1;
    step(15);
    chk("abort_no_capture", 32'(d4), 32'd0);
    chk("abort_ack_held", 32'(ack4), 32'd0);

    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
